// File: rtl/tdl_pkg.sv
// Shared constants and helpers for the tap delay line.
package tdl_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/tdl_tap_mux.sv
// Selects one stage of the delay line as the tap output.
module tdl_tap_mux
  import tdl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int SEL_W = clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] stages,
  input  logic [SEL_W-1:0]            sel,
  output logic [WIDTH-1:0]            tap
);

  // DEPTH is a power of two, so every sel value addresses a real stage.
  assign tap = stages[sel];

endmodule

// File: rtl/tap_delay_line.sv
// Programmable tap delay line: DEPTH-stage shift register with a selectable
// tap, recirculation, flush and a saturating fill counter.
module tap_delay_line
  import tdl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int SEL_W = clog2(DEPTH),
  localparam int CNT_W = SEL_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] delay_sel,
  input  logic             recirc,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_stb,
  output logic [CNT_W-1:0] fill_count
);

  // Handshake: in_valid is a pure strobe with no backpressure; every cycle it
  // is high (and flush is low) one sample is taken. out_stb pulses for one
  // cycle whenever a new valid sample lands on the selected tap.

  logic [DEPTH-1:0][WIDTH-1:0] stage;
  logic [WIDTH-1:0]            tap;
  logic [WIDTH-1:0]            new_sample;
  logic [CNT_W-1:0]            fill_next;

  tdl_tap_mux #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_tap_mux (
    .stages (stage),
    .sel    (delay_sel),
    .tap    (tap)
  );

  assign out_data  = tap;
  assign out_valid = fill_count > {1'b0, delay_sel};

  // Recirculation reuses the current tap and adds no new history.
  always_comb begin
    new_sample = in_data;
    fill_next  = fill_count;
    if (recirc) begin
      new_sample = tap;
    end else if (fill_count != CNT_W'(DEPTH)) begin
      fill_next = fill_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      stage      <= '0;
      fill_count <= '0;
      out_stb    <= 1'b0;
    end else if (in_valid) begin
      stage      <= {stage[DEPTH-2:0], new_sample};
      fill_count <= fill_next;
      out_stb    <= fill_next > {1'b0, delay_sel};
    end else begin
      out_stb    <= 1'b0;
    end
  end

endmodule

// File: doc/tap_delay_line.md
TAP_DELAY_LINE -- requirements
Module: tap_delay_line

Interface
REQ-001 Parameter WIDTH, default 8: sample width in bits.
REQ-002 Parameter DEPTH, default 16: number of storage stages; power of two, at least 2.
REQ-003 Derived constant SEL_W = clog2(DEPTH); CNT_W = SEL_W+1.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  accept strobe; one sample per high cycle, no backpressure.
REQ-007 in_data  input  WIDTH  sample accepted when in_valid=1.
REQ-008 delay_sel  input  SEL_W  tap select; delay = delay_sel+1 accepted samples.
REQ-009 recirc  input  1  when high, an accepted strobe feeds the tap back into stage 0 and ignores in_data.
REQ-010 flush  input  1  clears stored history.
REQ-011 out_data  output  WIDTH  current tap value, stage[delay_sel].
REQ-012 out_valid  output  1  high when fill_count > delay_sel.
REQ-013 out_stb  output  1  one-cycle pulse marking a new sample at the tap.
REQ-014 fill_count  output  CNT_W  number of valid stages, saturating at DEPTH.

Function
REQ-015 Storage SHALL be DEPTH registers stage[0..DEPTH-1]; stage[0] holds the newest sample.
REQ-016 Accept (in_valid=1, flush=0, recirc=0): stage[0]<=in_data, stage[i]<=stage[i-1]; stage[DEPTH-1] is discarded; fill_count<=min(fill_count+1, DEPTH).
REQ-017 Recirculate (in_valid=1, flush=0, recirc=1): stage[0]<=stage[delay_sel] and other stages shift as in REQ-016; fill_count unchanged.
REQ-018 in_valid=0 with flush=0: all stages and fill_count SHALL hold.
REQ-019 flush=1: all stages<=0 and fill_count<=0 next cycle; flush has priority over in_valid and recirc, and the concurrent sample is dropped.
REQ-020 out_data and out_valid SHALL be combinational from registered state and delay_sel only, with no path from in_data.
REQ-021 Accept-to-output latency: the sample accepted in cycle N appears at stage[0] in cycle N+1.
REQ-022 A delay_sel change SHALL take effect in the same cycle: out_data and out_valid are re-evaluated and no data moves.
REQ-023 out_stb SHALL be registered: it is high in cycle N+1 iff cycle N was an accept or recirculate and the post-update fill_count > delay_sel; otherwise 0.
REQ-024 fill_count SHALL never exceed DEPTH or wrap; once saturated, further accepts leave it at DEPTH.
REQ-025 Under recirc with fill_count <= delay_sel, zero or stale stage contents are circulated and out_valid stays 0.

Reset
REQ-026 When reset=1 at a clock edge, all stages, fill_count and out_stb SHALL be 0 next cycle; out_data=0 and out_valid=0 follow.
REQ-027 Reset SHALL override flush, in_valid and recirc, including mid-stream.

Structure
REQ-028 Package tdl_pkg SHALL hold the default WIDTH/DEPTH constants and the clog2 helper.
REQ-029 The tap multiplexer SHALL be a sub-module, tdl_tap_mux (DEPTH x WIDTH to WIDTH); everything else is inline.

Verification (WIDTH=8, DEPTH=16)
REQ-030 delay_sel=9; accept 0x01..0x0A -> out_valid rises the cycle after the 10th accept with out_data=0x01; accept 0x0B -> out_data=0x02, out_stb pulses once.
REQ-031 delay_sel=0; accept 0x5A -> next cycle out_data=0x5A, out_valid=1, fill_count=1.
REQ-032 delay_sel=15; accept 0x01..0x14 (20 samples) -> fill_count=16, out_data=0x05; switching delay_sel to 0 -> same cycle out_data=0x14.
REQ-033 delay_sel=3; load 0xA0..0xA3, then recirc with in_valid for 4 cycles -> out_data sequence 0xA0, 0xA1, 0xA2, 0xA3, 0xA0 and fill_count stays 4.
REQ-034 With 5 samples stored, flush=1 and in_valid=1 (in_data=0x77) together -> next cycle fill_count=0, out_valid=0, all stages 0, and 0x77 is never seen.
REQ-035 Mid-stream reset=1 with in_valid=1 -> next cycle all outputs 0; accepts resume normally after reset deasserts.
